// File: rtl/i2c_slave_regfile_if.sv
// Bus-side signals of the I2C register-file target: pin levels, open-drain
// enables and the side-band strobes that scoreboards observe.
interface i2c_slave_regfile_if #(
   parameter int PW = 4,
   parameter int DW = 8
);
   logic          scl_i;
   logic          sda_i;
   logic          scl_oe;
   logic          sda_oe;
   logic          busy;
   logic          start_det;
   logic          stop_det;
   logic          wr_stb;
   logic          rd_stb;
   logic [PW-1:0] acc_addr;
   logic [DW-1:0] acc_data;

   modport slave (
      input  scl_i, sda_i,
      output scl_oe, sda_oe, busy, start_det, stop_det, wr_stb, rd_stb, acc_addr, acc_data
   );

   modport master (
      output scl_i, sda_i,
      input  scl_oe, sda_oe, busy, start_det, stop_det, wr_stb, rd_stb, acc_addr, acc_data
   );
endinterface

// File: rtl/i2c_slave_regfile.sv
// Oversampling I2C target with an auto-incrementing register file.
// Optional SCL clock stretching after ACK slots is enabled by defining I2C_STRETCH_EN.
module i2c_slave_regfile #(
   parameter int                        I2C_ADDR_WIDTH = 7,
   parameter int                        I2C_DATA_WIDTH = 8,
   parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
   parameter int                        MEM_DEPTH      = 16,
   parameter int                        SYNC_STAGES    = 2,
   parameter int                        STRETCH_CYCLES = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   i2c_slave_regfile_if.slave bus
);
   localparam int PW  = $clog2(MEM_DEPTH);
   localparam int DW  = I2C_DATA_WIDTH;
   localparam int BCW = $clog2(DW + 1);

   generate
      if (I2C_ADDR_WIDTH != 7 || SYNC_STAGES < 2 || STRETCH_CYCLES < 1 ||
          MEM_DEPTH < 2 || MEM_DEPTH > 256 || (1 << PW) != MEM_DEPTH) begin : g_bad_params
         $error("i2c_slave_regfile: unsupported parameter set");
      end
   endgenerate

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, WDATA, WACK, RDATA, RACK, IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_reg, scl_sync_next;
   logic [SYNC_STAGES-1:0] sda_sync_reg, sda_sync_next;
   logic                   scl_prev_reg, sda_prev_reg;
   logic                   scl_s, sda_s;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign scl_sync_next[gi] = bus.scl_i;
            assign sda_sync_next[gi] = bus.sda_i;
         end else begin : g_rest
            assign scl_sync_next[gi] = scl_sync_reg[gi-1];
            assign sda_sync_next[gi] = sda_sync_reg[gi-1];
         end
      end
   endgenerate

   // Preset to 1 so a reset never looks like a START/STOP on the idle bus.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_sync_reg <= '1;
         sda_sync_reg <= '1;
         scl_prev_reg <= 1'b1;
         sda_prev_reg <= 1'b1;
      end else begin
         scl_sync_reg <= scl_sync_next;
         sda_sync_reg <= sda_sync_next;
         scl_prev_reg <= scl_s;
         sda_prev_reg <= sda_s;
      end
   end

   assign scl_s = scl_sync_reg[SYNC_STAGES-1];
   assign sda_s = sda_sync_reg[SYNC_STAGES-1];

   logic scl_rise, scl_fall, start_cond, stop_cond;
   assign scl_rise   = scl_s & ~scl_prev_reg;
   assign scl_fall   = ~scl_s & scl_prev_reg;
   assign start_cond = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
   assign stop_cond  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

   state_t         state_reg;
   logic [BCW-1:0] bit_cnt_reg;
   logic [DW-1:0]  rx_reg, tx_reg, rx_next;
   logic           rw_reg, ack_phase_reg;
   logic [PW-1:0]  ptr_reg;
   logic [DW-1:0]  mem [MEM_DEPTH];
   logic           sda_oe_reg, busy_reg, start_det_reg, stop_det_reg;
   logic           wr_stb_reg, rd_stb_reg;
   logic [PW-1:0]  acc_addr_reg;
   logic [DW-1:0]  acc_data_reg;
   logic           load_rd;

   assign rx_next = {rx_reg[DW-2:0], sda_s};
   // The falling edge that closes an ACK slot ahead of a read byte fetches the next byte.
   assign load_rd = scl_fall &&
                    ((state_reg == ADDR_ACK && ack_phase_reg && rw_reg) || state_reg == RACK);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         rx_reg        <= '0;
         tx_reg        <= '0;
         rw_reg        <= 1'b0;
         ack_phase_reg <= 1'b0;
         ptr_reg       <= '0;
         sda_oe_reg    <= 1'b0;
         busy_reg      <= 1'b0;
         start_det_reg <= 1'b0;
         stop_det_reg  <= 1'b0;
         wr_stb_reg    <= 1'b0;
         rd_stb_reg    <= 1'b0;
         acc_addr_reg  <= '0;
         acc_data_reg  <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else begin
         start_det_reg <= start_cond;
         stop_det_reg  <= stop_cond;
         wr_stb_reg    <= 1'b0;
         rd_stb_reg    <= 1'b0;
         if (start_cond) begin
            state_reg     <= ADDR;
            bit_cnt_reg   <= '0;
            ack_phase_reg <= 1'b0;
            sda_oe_reg    <= 1'b0;
         end else if (stop_cond) begin
            state_reg     <= IDLE;
            ack_phase_reg <= 1'b0;
            sda_oe_reg    <= 1'b0;
            busy_reg      <= 1'b0;
         end else if (load_rd) begin
            tx_reg        <= {mem[ptr_reg][DW-2:0], 1'b0};
            sda_oe_reg    <= ~mem[ptr_reg][DW-1];
            rd_stb_reg    <= 1'b1;
            acc_addr_reg  <= ptr_reg;
            acc_data_reg  <= mem[ptr_reg];
            ptr_reg       <= ptr_reg + PW'(1);
            bit_cnt_reg   <= '0;
            ack_phase_reg <= 1'b0;
            state_reg     <= RDATA;
         end else begin
            case (state_reg)
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     rx_reg      <= rx_next;
                     bit_cnt_reg <= bit_cnt_reg + BCW'(1);
                     if (bit_cnt_reg == BCW'(DW - 1)) begin
                        bit_cnt_reg <= '0;
                        if (state_reg == ADDR) begin
                           if (rx_next[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
                              busy_reg  <= 1'b1;
                              rw_reg    <= rx_next[0];
                              state_reg <= ADDR_ACK;
                           end else begin
                              busy_reg  <= 1'b0;
                              state_reg <= IGNORE;
                           end
                        end else if (state_reg == PTR) begin
                           ptr_reg   <= rx_next[PW-1:0];
                           state_reg <= WACK;
                        end else begin
                           mem[ptr_reg] <= rx_next;
                           wr_stb_reg   <= 1'b1;
                           acc_addr_reg <= ptr_reg;
                           acc_data_reg <= rx_next;
                           ptr_reg      <= ptr_reg + PW'(1);
                           state_reg    <= WACK;
                        end
                     end
                  end
               end
               ADDR_ACK, WACK: begin
                  // First fall opens the ACK slot, second fall closes it.
                  if (scl_fall) begin
                     if (!ack_phase_reg) begin
                        sda_oe_reg    <= 1'b1;
                        ack_phase_reg <= 1'b1;
                     end else begin
                        sda_oe_reg    <= 1'b0;
                        ack_phase_reg <= 1'b0;
                        state_reg     <= (state_reg == ADDR_ACK) ? PTR : WDATA;
                     end
                  end
               end
               RDATA: begin
                  if (scl_rise) bit_cnt_reg <= bit_cnt_reg + BCW'(1);
                  if (scl_fall) begin
                     if (bit_cnt_reg == BCW'(DW)) begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= RACK;
                     end else begin
                        sda_oe_reg <= ~tx_reg[DW-1];
                        tx_reg     <= {tx_reg[DW-2:0], 1'b0};
                     end
                  end
               end
               RACK: begin
                  if (scl_rise && sda_s) state_reg <= IGNORE;
               end
               default: begin
                  sda_oe_reg <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef I2C_STRETCH_EN
   localparam int SCW = $clog2(STRETCH_CYCLES + 1);
   logic           stretch_start;
   logic [SCW-1:0] stretch_cnt_reg;
   logic           scl_oe_reg;

   assign stretch_start = scl_fall &&
                          (((state_reg == ADDR_ACK || state_reg == WACK) && ack_phase_reg) ||
                           state_reg == RACK);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stretch_cnt_reg <= '0;
         scl_oe_reg      <= 1'b0;
      end else if (stretch_start) begin
         stretch_cnt_reg <= SCW'(STRETCH_CYCLES);
         scl_oe_reg      <= 1'b1;
      end else if (stretch_cnt_reg != '0) begin
         stretch_cnt_reg <= stretch_cnt_reg - SCW'(1);
         scl_oe_reg      <= (stretch_cnt_reg > SCW'(1));
      end
   end

   assign bus.scl_oe = scl_oe_reg;
`else
   assign bus.scl_oe = 1'b0;
`endif

   assign bus.sda_oe    = sda_oe_reg;
   assign bus.busy      = busy_reg;
   assign bus.start_det = start_det_reg;
   assign bus.stop_det  = stop_det_reg;
   assign bus.wr_stb    = wr_stb_reg;
   assign bus.rd_stb    = rd_stb_reg;
   assign bus.acc_addr  = acc_addr_reg;
   assign bus.acc_data  = acc_data_reg;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master drives table
// vectors for write transactions plus hand-written read/abort/reset sequences.
module tb_i2c_slave_regfile;
   localparam int Q = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_drv = 1'b1;
   logic sda_drv = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;

   i2c_slave_regfile_if #(.PW(4), .DW(8)) bus ();
   assign bus.scl_i = scl_drv & ~bus.scl_oe;
   assign bus.sda_i = sda_drv & ~bus.sda_oe;

   i2c_slave_regfile #(.SLAVE_ADDR(7'h22), .MEM_DEPTH(16)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int         wr_cnt = 0, rd_cnt = 0, busy_cyc = 0, start_cnt = 0;
   logic [3:0] wr_addr_log [256];
   logic [7:0] wr_data_log [256];
   logic [3:0] rd_addr_log [256];
   logic [7:0] rd_data_log [256];

   always @(negedge clk) begin
      if (bus.wr_stb) begin
         wr_addr_log[wr_cnt % 256] <= bus.acc_addr;
         wr_data_log[wr_cnt % 256] <= bus.acc_data;
         wr_cnt <= wr_cnt + 1;
      end
      if (bus.rd_stb) begin
         rd_addr_log[rd_cnt % 256] <= bus.acc_addr;
         rd_data_log[rd_cnt % 256] <= bus.acc_data;
         rd_cnt <= rd_cnt + 1;
      end
      if (bus.busy) busy_cyc <= busy_cyc + 1;
      if (bus.start_det) start_cnt <= start_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic wait_scl_high();
      int n;
      n = 0;
      while (bus.scl_i !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.scl_i !== 1'b1) begin
         n_assert++;
         n_fail++;
         $display("FAIL scl_release: actual=low required=high within 100 cycles");
      end
   endtask

   task automatic clk_bit(input logic b, output logic sampled);
      sda_drv = b;
      wait_q();
      scl_drv = 1'b1;
      wait_scl_high();
      wait_q();
      sampled = bus.sda_i;
      wait_q();
      scl_drv = 1'b0;
      wait_q();
   endtask

   task automatic send_start();
      sda_drv = 1'b1;
      wait_q();
      scl_drv = 1'b1;
      wait_scl_high();
      wait_q();
      sda_drv = 1'b0;
      wait_q();
      scl_drv = 1'b0;
      wait_q();
   endtask

   task automatic send_stop(input logic exp_busy, input string tag);
      sda_drv = 1'b0;
      wait_q();
      scl_drv = 1'b1;
      wait_scl_high();
      wait_q();
      sda_drv = 1'b1;
      repeat (2) @(negedge clk);
      check({tag, "_busy_before_stop"}, 32'(bus.busy), 32'(exp_busy));
      @(negedge clk);
      check({tag, "_stop_det"}, 32'(bus.stop_det), 32'd1);
      check({tag, "_busy_after_stop"}, 32'(bus.busy), 32'd0);
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(~master_ack, s);
   endtask

   typedef struct {
      logic [7:0]      addr_byte;
      logic [7:0]      ptr_byte;
      int              nbytes;
      logic [2:0][7:0] data;
      logic            exp_ack;
      int              exp_wr;
      logic [2:0][3:0] exp_waddr;
      logic            exp_busy;
   } wvec_t;

   wvec_t      vecs [4];
   logic       ack, s, seen;
   logic [7:0] d, byte_v;
   int         w0, b0, r0, s0;

   initial begin
      vecs[0] = '{8'h44, 8'h03, 2, {8'h00, 8'h5A, 8'hA5}, 1'b1, 2, {4'h0, 4'h4, 4'h3}, 1'b1};
      vecs[1] = '{8'h46, 8'h03, 2, {8'h00, 8'h88, 8'h77}, 1'b0, 0, {4'h0, 4'h0, 4'h0}, 1'b0};
      vecs[2] = '{8'h44, 8'h08, 1, {8'h00, 8'h00, 8'hC3}, 1'b1, 1, {4'h0, 4'h0, 4'h8}, 1'b1};
      vecs[3] = '{8'h44, 8'h0F, 3, {8'h03, 8'h02, 8'h01}, 1'b1, 3, {4'h1, 4'h0, 4'hF}, 1'b1};

      repeat (4) @(negedge clk);
      check("reset_sda_oe", 32'(bus.sda_oe), 32'd0);
      check("reset_scl_oe", 32'(bus.scl_oe), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_strobes", {30'd0, bus.wr_stb, bus.rd_stb}, 32'd0);
      check("reset_acc", {20'd0, bus.acc_addr, bus.acc_data}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_detects", {30'd0, bus.start_det, bus.stop_det}, 32'd0);

      for (int v = 0; v < 4; v++) begin
         w0 = wr_cnt;
         b0 = busy_cyc;
         send_start();
         write_byte(vecs[v].addr_byte, ack);
         check($sformatf("v%0d_addr_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
         write_byte(vecs[v].ptr_byte, ack);
         check($sformatf("v%0d_ptr_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
         for (int k = 0; k < vecs[v].nbytes; k++) begin
            write_byte(vecs[v].data[k], ack);
            check($sformatf("v%0d_data%0d_ack", v, k), 32'(ack), 32'(vecs[v].exp_ack));
         end
         send_stop(vecs[v].exp_busy, $sformatf("v%0d", v));
         check($sformatf("v%0d_wr_count", v), 32'(wr_cnt - w0), 32'(vecs[v].exp_wr));
         for (int k = 0; k < vecs[v].exp_wr; k++) begin
            check($sformatf("v%0d_wr%0d_addr", v, k), 32'(wr_addr_log[(w0 + k) % 256]),
                  32'(vecs[v].exp_waddr[k]));
            check($sformatf("v%0d_wr%0d_data", v, k), 32'(wr_data_log[(w0 + k) % 256]),
                  32'(vecs[v].data[k]));
         end
         check($sformatf("v%0d_busy_seen", v), 32'(busy_cyc != b0), 32'(vecs[v].exp_busy));
         $display("vector %0d: addr=%02h ptr=%02h bytes=%0d writes=%0d",
                  v, vecs[v].addr_byte, vecs[v].ptr_byte, vecs[v].nbytes, wr_cnt - w0);
      end

      // Pointer wrapped 15 -> 0 -> 1 -> 2; a fresh read must start at 2.
      r0 = rd_cnt;
      send_start();
      write_byte(8'h45, ack);
      check("wrap_read_addr_ack", 32'(ack), 32'd1);
      read_byte(1'b0, d);
      send_stop(1'b1, "wrap");
      check("wrap_rd_ptr", 32'(rd_addr_log[r0 % 256]), 32'd2);
      $display("sequence wrap: read ptr=%0d data=%02h", rd_addr_log[r0 % 256], d);

      // Write pointer, repeated START, read two bytes (ACK then NACK).
      r0 = rd_cnt;
      s0 = start_cnt;
      send_start();
      write_byte(8'h44, ack);
      check("rs_addr_w_ack", 32'(ack), 32'd1);
      write_byte(8'h03, ack);
      check("rs_ptr_ack", 32'(ack), 32'd1);
      send_start();
      write_byte(8'h45, ack);
      check("rs_addr_r_ack", 32'(ack), 32'd1);
      read_byte(1'b1, d);
      check("rs_sda_byte0", 32'(d), 32'hA5);
      read_byte(1'b0, d);
      check("rs_sda_byte1", 32'(d), 32'h5A);
      repeat (3) @(negedge clk);
      check("rs_nack_release", 32'(bus.sda_oe), 32'd0);
      send_stop(1'b1, "rs");
      check("rs_start_count", 32'(start_cnt - s0), 32'd2);
      check("rs_rd_count", 32'(rd_cnt - r0), 32'd2);
      check("rs_rd0_addr", 32'(rd_addr_log[r0 % 256]), 32'd3);
      check("rs_rd0_data", 32'(rd_data_log[r0 % 256]), 32'hA5);
      check("rs_rd1_addr", 32'(rd_addr_log[(r0 + 1) % 256]), 32'd4);
      check("rs_rd1_data", 32'(rd_data_log[(r0 + 1) % 256]), 32'h5A);
      $display("sequence repeated-start read: bytes=%0d", rd_cnt - r0);

      r0 = rd_cnt;
      send_start();
      write_byte(8'h45, ack);
      read_byte(1'b0, d);
      send_stop(1'b1, "ptr5");
      check("ptr5_rd_addr", 32'(rd_addr_log[r0 % 256]), 32'd5);
      $display("sequence pointer persistence: read ptr=%0d", rd_addr_log[r0 % 256]);

      // STOP four bits into a data byte: no write, pointer stays at 7.
      w0 = wr_cnt;
      send_start();
      write_byte(8'h44, ack);
      write_byte(8'h07, ack);
      check("abort_ptr_ack", 32'(ack), 32'd1);
      clk_bit(1'b1, s);
      clk_bit(1'b0, s);
      clk_bit(1'b1, s);
      clk_bit(1'b1, s);
      send_stop(1'b1, "abort");
      check("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
      r0 = rd_cnt;
      send_start();
      write_byte(8'h45, ack);
      check("abort_next_ack", 32'(ack), 32'd1);
      read_byte(1'b0, d);
      send_stop(1'b1, "after_abort");
      check("abort_ptr_kept", 32'(rd_addr_log[r0 % 256]), 32'd7);
      $display("sequence abort: writes=%0d next read ptr=%0d", wr_cnt - w0, rd_addr_log[r0 % 256]);

      // Reset while the target drives the address ACK.
      byte_v = 8'h44;
      send_start();
      for (int i = 7; i >= 0; i--) clk_bit(byte_v[i], s);
      sda_drv = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.sda_oe;
      end
      check("rst_ack_driven", 32'(seen), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_sda_release", 32'(bus.sda_oe), 32'd0);
      check("rst_busy_clear", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      wait_q();
      scl_drv = 1'b1;
      wait_scl_high();
      wait_q();
      r0 = rd_cnt;
      send_start();
      write_byte(8'h45, ack);
      check("rst_read_ack", 32'(ack), 32'd1);
      for (int k = 0; k < 16; k++) begin
         read_byte(k != 15, d);
         check($sformatf("rst_mem%0d_sda", k), 32'(d), 32'd0);
      end
      send_stop(1'b1, "rst");
      check("rst_rd_count", 32'(rd_cnt - r0), 32'd16);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("rst_rd%0d_addr", k), 32'(rd_addr_log[(r0 + k) % 256]), 32'(k));
         check($sformatf("rst_rd%0d_data", k), 32'(rd_data_log[(r0 + k) % 256]), 32'd0);
      end
      $display("sequence reset mid-ACK: read back %0d bytes", rd_cnt - r0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Synthesizable, clocked I2C target that replaces the behavioural slave model used on the bench.
- Oversamples SCL/SDA and detects START, repeated START and STOP.
- Matches a parametrised slave address, ACKs address and write bytes, and keeps a pointer into an internal register file that auto-increments.
- Sits behind the IICMB master in the DUT harness. Side-band strobes let scoreboards observe writes and reads without bus decoding.

Parameters:
- I2C_ADDR_WIDTH, 7, slave address width in bits; only 7 is supported.
- I2C_DATA_WIDTH, 8, data byte width.
- SLAVE_ADDR, 7'h22, address this target responds to.
- MEM_DEPTH, 16, register-file entries; must be a power of two, 2..256. PW = $clog2(MEM_DEPTH).
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizer; minimum 2.
- STRETCH_CYCLES, 8, clk_i cycles SCL is held low when I2C_STRETCH_EN is defined.

Ports:
- clk_i, input, 1, system clock; at least 8x the SCL frequency.
- rst_i, input, 1, synchronous active-high reset.
- scl_i, input, 1, SCL pin level.
- sda_i, input, 1, SDA pin level.
- scl_oe, output, 1, 1 = pull SCL low (open-drain).
- sda_oe, output, 1, 1 = pull SDA low (open-drain).
- busy, output, 1, high from an address match until STOP or abort.
- start_det, output, 1, one-cycle pulse on START or repeated START.
- stop_det, output, 1, one-cycle pulse on STOP.
- wr_stb, output, 1, one-cycle pulse when a data byte is written to the register file.
- rd_stb, output, 1, one-cycle pulse when a byte is loaded for transmit.
- acc_addr, output, PW, pointer used by the current wr_stb or rd_stb.
- acc_data, output, I2C_DATA_WIDTH, byte written or read.

Behaviour:
- Reset:
  - rst_i is synchronous and active-high.
  - All outputs go to 0; FSM to IDLE; pointer to 0; register file cleared to 0.
  - Synchronizers preset to 1 (bus idle).
  - Reset asserted mid-transfer releases SDA/SCL on the next clk_i edge.
- Edge detection:
  - Uses the synchronized scl_s/sda_s and their previous values.
  - START = sda_s falls while scl_s is high.
  - STOP = sda_s rises while scl_s is high.
  - Detect pulse follows the pin edge by SYNC_STAGES+1 clocks.
  - START or STOP in any state overrides everything: the FSM goes to ADDR on START and IDLE on STOP. sda_oe is released the same cycle.
- Bit timing:
  - Bits are sampled on a rising scl_s edge, MSB first.
  - sda_oe changes only on a falling scl_s edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (address plus R/W).
    - Match with W: go to ADDR_ACK.
    - Match with R: go to ADDR_ACK, then RDATA.
    - Mismatch: go to IGNORE with sda_oe=0 (NACK).
  - ADDR_ACK: sda_oe=1 from the falling edge after bit 8 to the falling edge after bit 9.
  - PTR: first write byte; pointer <= byte[PW-1:0]; then ACK.
  - WDATA: each further byte:
    - write mem[ptr], pulse wr_stb with acc_addr=ptr, then ptr <= ptr+1 mod MEM_DEPTH;
    - ACK.
  - RDATA:
    - On the falling edge that ends the ACK, load mem[ptr], pulse rd_stb, ptr++.
    - Drive the byte: sda_oe = ~bit.
    - Release SDA for the master's ACK slot.
    - Sample the ACK bit: 0 = continue in RDATA; 1 (NACK) = go to IGNORE.
  - IGNORE: sda_oe=0; leave only on START or STOP.
- Pointer:
  - Wraps MEM_DEPTH-1 -> 0 with no error.
  - Persists across transactions; a repeated-START read continues at the last pointer.
- busy:
  - Set on the address match.
  - Cleared on STOP, on a mismatched repeated START, or on reset.
- A STOP in the middle of a byte discards the partial byte: no wr_stb, pointer unchanged.

Optional Feature:
- Macro: I2C_STRETCH_EN.
- Defined: after every ACK/NACK bit this target completes (address or write byte), and before each read byte, scl_oe is held at 1 for STRETCH_CYCLES clk_i cycles starting at the falling scl_s edge, then released.
- Not defined: scl_oe is tied to 0 and no stretch logic exists.

Test Plan:
- Write 0x44, 0x03, 0xA5, 0x5A, then STOP:
  - ADDR/PTR/data all ACKed;
  - wr_stb twice with (3,0xA5) and (4,0x5A);
  - busy drops 1+SYNC_STAGES clocks after STOP.
- Write 0x44, 0x03, then repeated START, 0x45, read 2 bytes with master ACK then NACK:
  - SDA carries 0xA5 then 0x5A;
  - rd_stb twice;
  - target releases SDA after the NACK;
  - ptr=5.
- Address 0x46 (slave 0x23) followed by data bytes:
  - every 9th bit NACKed;
  - no strobes; busy stays 0.
- Pointer 0x0F with 3 data bytes 1,2,3 (MEM_DEPTH=16):
  - writes land at 15, 0, 1; ptr ends at 2.
- STOP after 4 bits of a data byte:
  - no wr_stb; FSM IDLE; the next transaction starts cleanly.
- rst_i pulsed while the target drives an ACK:
  - sda_oe=0 the next cycle;
  - mem[0..15]=0; ptr=0.
- With I2C_STRETCH_EN: scl_oe is high exactly 8 cycles after each ACK falling edge.
